// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller for the 5-stage MIPS pipeline: load-use bubbles, branch/jump
// squashes, data-memory wait with timeout, and saturating stall/flush counters.
module pipeline_hazard_ctrl #(
   parameter int MEM_TIMEOUT = 15,
   parameter int CNT_W       = 16
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             idex_MemRead_i,
   input  logic [4:0]       idex_Rt_i,
   input  logic [4:0]       ifid_Rs_i,
   input  logic [4:0]       ifid_Rt_i,
   input  logic             ifid_use_rs_i,
   input  logic             ifid_use_rt_i,
   input  logic             id_jump_i,
   input  logic             ex_branch_taken_i,
   input  logic             exmem_mem_req_i,
   input  logic             dmem_ready_i,
   output logic             pc_en_o,
   output logic             ifid_en_o,
   output logic             ifid_flush_o,
   output logic             idex_en_o,
   output logic             idex_flush_o,
   output logic             exmem_en_o,
   output logic             memwb_flush_o,
   output logic             mem_err_o,
   output logic [CNT_W-1:0] stall_cnt_o,
   output logic [CNT_W-1:0] flush_cnt_o
);

   typedef enum logic [1:0] {RUN, MEMWAIT, ERR} state_t;

   // wait_cnt counts stall cycles already completed, so the timeout fires at the end of
   // stall cycle MEM_TIMEOUT, i.e. when MEM_TIMEOUT-1 cycles have been completed before it.
   localparam logic [7:0]       LAST_WAIT = 8'(MEM_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] CNT_MAX   = '1;

   state_t           state_q, state_d;
   logic [7:0]       wait_cnt_q, wait_cnt_d;
   logic             mem_err_q, mem_err_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

   logic memStall;
   logic loadUse;

   assign memStall = exmem_mem_req_i & ~dmem_ready_i;
   assign loadUse  = idex_MemRead_i & (idex_Rt_i != 5'd0) &
                     ((ifid_use_rs_i & (ifid_Rs_i == idex_Rt_i)) |
                      (ifid_use_rt_i & (ifid_Rt_i == idex_Rt_i)));

   always_comb begin
      pc_en_o       = 1'b1;
      ifid_en_o     = 1'b1;
      ifid_flush_o  = 1'b0;
      idex_en_o     = 1'b1;
      idex_flush_o  = 1'b0;
      exmem_en_o    = 1'b1;
      memwb_flush_o = 1'b0;
      if (reset_i) begin
         pc_en_o       = 1'b0;
         ifid_en_o     = 1'b0;
         idex_en_o     = 1'b0;
         exmem_en_o    = 1'b0;
         ifid_flush_o  = 1'b1;
         idex_flush_o  = 1'b1;
         memwb_flush_o = 1'b1;
      end else if ((state_q == ERR) || memStall) begin
         pc_en_o       = 1'b0;
         ifid_en_o     = 1'b0;
         idex_en_o     = 1'b0;
         exmem_en_o    = 1'b0;
         memwb_flush_o = 1'b1;
      end else if (ex_branch_taken_i) begin
         ifid_flush_o = 1'b1;
         idex_flush_o = 1'b1;
      end else if (loadUse) begin
         pc_en_o      = 1'b0;
         ifid_en_o    = 1'b0;
         idex_flush_o = 1'b1;
      end else if (id_jump_i) begin
         ifid_flush_o = 1'b1;
      end
   end

   always_comb begin
      state_d    = state_q;
      wait_cnt_d = wait_cnt_q;
      mem_err_d  = mem_err_q;
      case (state_q)
         RUN: begin
            wait_cnt_d = 8'd0;
            if (memStall) begin
               if (LAST_WAIT == 8'd0) begin
                  state_d   = ERR;
                  mem_err_d = 1'b1;
               end else begin
                  state_d    = MEMWAIT;
                  wait_cnt_d = 8'd1;
               end
            end
         end
         MEMWAIT: begin
            if (dmem_ready_i || !exmem_mem_req_i) begin
               state_d    = RUN;
               wait_cnt_d = 8'd0;
            end else if (wait_cnt_q == LAST_WAIT) begin
               state_d    = ERR;
               wait_cnt_d = 8'd0;
               mem_err_d  = 1'b1;
            end else begin
               wait_cnt_d = wait_cnt_q + 8'd1;
            end
         end
         ERR:     state_d = ERR;
         default: state_d = RUN;
      endcase

      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (!pc_en_o && (stall_cnt_q != CNT_MAX)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
      if (ifid_flush_o && (flush_cnt_q != CNT_MAX)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q     <= RUN;
         wait_cnt_q  <= 8'd0;
         mem_err_q   <= 1'b0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         wait_cnt_q  <= wait_cnt_d;
         mem_err_q   <= mem_err_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign mem_err_o   = mem_err_q;
   assign stall_cnt_o = stall_cnt_q;
   assign flush_cnt_o = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed scenarios plus randomized traffic
// compared against a cycle-level behavioural model of the hazard rules.
module tb_pipeline_hazard_ctrl;

   localparam int TMO  = 4;
   localparam int CW   = 4;
   localparam int CMAX = (1 << CW) - 1;

   localparam logic [6:0] C_RESET  = 7'b0010101;
   localparam logic [6:0] C_FROZEN = 7'b0000001;
   localparam logic [6:0] C_BRANCH = 7'b1111110;
   localparam logic [6:0] C_LOADU  = 7'b0001110;
   localparam logic [6:0] C_JUMP   = 7'b1111010;
   localparam logic [6:0] C_IDLE   = 7'b1101010;

   logic clk = 1'b0;
   logic reset, idexMemRead, ifidUseRs, ifidUseRt, idJump, exBranchTaken, exmemMemReq, dmemReady;
   logic [4:0] idexRt, ifidRs, ifidRt;
   logic pcEn, ifidEn, ifidFlush, idexEn, idexFlush, exmemEn, memwbFlush, memErr;
   logic [CW-1:0] stallCnt, flushCnt;
   logic [6:0] dutCtrl;

   int checks = 0;
   int errors = 0;

   int  mRun   = 0;
   bit  mErr   = 1'b0;
   int  mStall = 0;
   int  mFlush = 0;

   pipeline_hazard_ctrl #(.MEM_TIMEOUT(TMO), .CNT_W(CW)) dut (
      .clk_i(clk), .reset_i(reset),
      .idex_MemRead_i(idexMemRead), .idex_Rt_i(idexRt),
      .ifid_Rs_i(ifidRs), .ifid_Rt_i(ifidRt),
      .ifid_use_rs_i(ifidUseRs), .ifid_use_rt_i(ifidUseRt),
      .id_jump_i(idJump), .ex_branch_taken_i(exBranchTaken),
      .exmem_mem_req_i(exmemMemReq), .dmem_ready_i(dmemReady),
      .pc_en_o(pcEn), .ifid_en_o(ifidEn), .ifid_flush_o(ifidFlush),
      .idex_en_o(idexEn), .idex_flush_o(idexFlush), .exmem_en_o(exmemEn),
      .memwb_flush_o(memwbFlush), .mem_err_o(memErr),
      .stall_cnt_o(stallCnt), .flush_cnt_o(flushCnt)
   );

   assign dutCtrl = {pcEn, ifidEn, ifidFlush, idexEn, idexFlush, exmemEn, memwbFlush};

   always #5 clk = ~clk;

   // Expected control vector {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_flush}
   function automatic logic [6:0] expCtrl();
      bit lu;
      lu = idexMemRead && (idexRt != 0) &&
           ((ifidUseRs && ifidRs == idexRt) || (ifidUseRt && ifidRt == idexRt));
      if (reset) return C_RESET;
      if (mErr || (exmemMemReq && !dmemReady)) return C_FROZEN;
      if (exBranchTaken) return C_BRANCH;
      if (lu) return C_LOADU;
      if (idJump) return C_JUMP;
      return C_IDLE;
   endfunction

   task automatic applyStimulus(input bit rst, input bit mr, input logic [4:0] rt,
                                input logic [4:0] rs, input logic [4:0] irt,
                                input bit urs, input bit urt, input bit j, input bit br,
                                input bit req, input bit rdy);
      @(negedge clk);
      reset = rst; idexMemRead = mr; idexRt = rt; ifidRs = rs; ifidRt = irt;
      ifidUseRs = urs; ifidUseRt = urt; idJump = j; exBranchTaken = br;
      exmemMemReq = req; dmemReady = rdy;
      #1;
   endtask

   task automatic idle();
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   // Advances the reference model across one rising edge using the inputs now applied
   task automatic clockModel();
      logic [6:0] e;
      e = expCtrl();
      @(posedge clk);
      if (reset) begin
         mErr = 0; mRun = 0; mStall = 0; mFlush = 0;
      end else begin
         if (!e[6] && mStall < CMAX) mStall++;
         if (e[4] && mFlush < CMAX) mFlush++;
         if (!mErr) begin
            if (exmemMemReq && !dmemReady) begin
               mRun++;
               if (mRun == TMO) begin mErr = 1; mRun = 0; end
            end else mRun = 0;
         end
      end
   endtask

   task automatic doReset();
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      clockModel();
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      clockModel();
   endtask

   task automatic test_reset();
      doReset();
      checks++;
      if (dutCtrl !== C_RESET) begin errors++; $display("[TB] FAIL reset_ctrl: got %b expected %b", dutCtrl, C_RESET); end
      idle();
      checks++;
      if (memErr !== 1'b0 || stallCnt !== 0 || flushCnt !== 0) begin
         errors++; $display("[TB] FAIL reset_regs: got err=%b stall=%0d flush=%0d expected 0/0/0", memErr, stallCnt, flushCnt);
      end
      checks++;
      if (dutCtrl !== C_IDLE) begin errors++; $display("[TB] FAIL reset_idle: got %b expected %b", dutCtrl, C_IDLE); end
      clockModel();
   endtask

   task automatic test_load_use();
      doReset();
      applyStimulus(0, 1, 8, 8, 0, 1, 0, 0, 0, 0, 0);
      checks++;
      if (dutCtrl !== C_LOADU) begin errors++; $display("[TB] FAIL load_use: got %b expected %b", dutCtrl, C_LOADU); end
      clockModel();
      applyStimulus(0, 0, 8, 8, 0, 1, 0, 0, 0, 0, 0);
      checks++;
      if (dutCtrl !== C_IDLE || stallCnt !== 4'd1) begin
         errors++; $display("[TB] FAIL load_use_after: got %b stall=%0d expected %b stall=1", dutCtrl, stallCnt, C_IDLE);
      end
      clockModel();
      applyStimulus(0, 1, 0, 0, 0, 1, 1, 0, 0, 0, 0);
      checks++;
      if (dutCtrl !== C_IDLE) begin errors++; $display("[TB] FAIL load_use_r0: got %b expected %b", dutCtrl, C_IDLE); end
      clockModel();
      applyStimulus(0, 1, 5, 1, 5, 0, 1, 0, 0, 0, 0);
      checks++;
      if (dutCtrl !== C_LOADU) begin errors++; $display("[TB] FAIL load_use_rt: got %b expected %b", dutCtrl, C_LOADU); end
      clockModel();
   endtask

   task automatic test_branch_priority();
      doReset();
      applyStimulus(0, 1, 8, 8, 0, 1, 0, 1, 1, 0, 0);
      checks++;
      if (dutCtrl !== C_BRANCH) begin errors++; $display("[TB] FAIL branch_prio: got %b expected %b", dutCtrl, C_BRANCH); end
      clockModel();
      idle();
      checks++;
      if (flushCnt !== 4'd1 || stallCnt !== 4'd0) begin
         errors++; $display("[TB] FAIL branch_counts: got flush=%0d stall=%0d expected 1/0", flushCnt, stallCnt);
      end
      clockModel();
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
      checks++;
      if (dutCtrl !== C_JUMP) begin errors++; $display("[TB] FAIL jump: got %b expected %b", dutCtrl, C_JUMP); end
      clockModel();
   endtask

   task automatic test_mem_wait();
      doReset();
      for (int i = 0; i < 3; i++) begin
         applyStimulus(0, 1, 8, 8, 0, 1, 0, 1, (i == 1), 1, 0);
         checks++;
         if (dutCtrl !== C_FROZEN) begin errors++; $display("[TB] FAIL mem_wait_%0d: got %b expected %b", i, dutCtrl, C_FROZEN); end
         clockModel();
      end
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
      checks++;
      if (dutCtrl !== C_IDLE || stallCnt !== 4'd3 || flushCnt !== 4'd0) begin
         errors++; $display("[TB] FAIL mem_wait_release: got %b stall=%0d flush=%0d expected %b 3 0", dutCtrl, stallCnt, flushCnt, C_IDLE);
      end
      clockModel();
   endtask

   task automatic test_timeout();
      doReset();
      for (int i = 1; i <= TMO; i++) begin
         applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
         checks++;
         if (dutCtrl !== C_FROZEN || memErr !== 1'b0) begin
            errors++; $display("[TB] FAIL timeout_stall_%0d: got %b err=%b expected %b err=0", i, dutCtrl, memErr, C_FROZEN);
         end
         clockModel();
      end
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      checks++;
      if (memErr !== 1'b1 || dutCtrl !== C_FROZEN) begin
         errors++; $display("[TB] FAIL timeout_err: got %b err=%b expected %b err=1", dutCtrl, memErr, C_FROZEN);
      end
      clockModel();
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1);
      checks++;
      if (memErr !== 1'b1 || dutCtrl !== C_FROZEN || stallCnt !== 4'(TMO + 1)) begin
         errors++; $display("[TB] FAIL err_frozen: got %b err=%b stall=%0d expected %b err=1 stall=%0d", dutCtrl, memErr, stallCnt, C_FROZEN, TMO + 1);
      end
      clockModel();
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      clockModel();
      idle();
      checks++;
      if (memErr !== 1'b0 || stallCnt !== 0 || flushCnt !== 0 || dutCtrl !== C_IDLE) begin
         errors++; $display("[TB] FAIL err_reset: got %b err=%b stall=%0d flush=%0d expected %b 0 0 0", dutCtrl, memErr, stallCnt, flushCnt, C_IDLE);
      end
      clockModel();
   endtask

   task automatic test_boundary_ready();
      doReset();
      for (int rep = 0; rep < 2; rep++) begin
         for (int i = 1; i < TMO; i++) begin
            applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
            clockModel();
         end
         applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
         checks++;
         if (dutCtrl !== C_IDLE) begin errors++; $display("[TB] FAIL boundary_ready_%0d: got %b expected %b", rep, dutCtrl, C_IDLE); end
         clockModel();
         applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
         checks++;
         if (memErr !== 1'b0 || dutCtrl !== C_JUMP) begin
            errors++; $display("[TB] FAIL boundary_run_%0d: got %b err=%b expected %b err=0", rep, dutCtrl, memErr, C_JUMP);
         end
         clockModel();
      end
   endtask

   task automatic test_saturation();
      doReset();
      for (int i = 0; i < 20; i++) begin
         applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
         clockModel();
      end
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
      checks++;
      if (flushCnt !== 4'd15) begin errors++; $display("[TB] FAIL flush_sat: got %0d expected 15", flushCnt); end
      checks++;
      if (dutCtrl !== C_RESET) begin errors++; $display("[TB] FAIL mid_reset_ctrl: got %b expected %b", dutCtrl, C_RESET); end
      clockModel();
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
      checks++;
      if (flushCnt !== 4'd0) begin errors++; $display("[TB] FAIL mid_reset_clear: got %0d expected 0", flushCnt); end
      clockModel();
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
      checks++;
      if (flushCnt !== 4'd1) begin errors++; $display("[TB] FAIL mid_reset_resume: got %0d expected 1", flushCnt); end
      clockModel();
   endtask

   task automatic test_random();
      logic [6:0] e;
      doReset();
      for (int i = 0; i < 600; i++) begin
         applyStimulus(($urandom_range(59) == 0), $urandom_range(1), 5'($urandom_range(3)),
                       5'($urandom_range(3)), 5'($urandom_range(3)), $urandom_range(1),
                       $urandom_range(1), ($urandom_range(3) == 0), ($urandom_range(4) == 0),
                       ($urandom_range(2) != 0), ($urandom_range(4) == 0));
         e = expCtrl();
         checks++;
         if (dutCtrl !== e || memErr !== mErr || stallCnt !== 4'(mStall) || flushCnt !== 4'(mFlush)) begin
            errors++;
            $display("[TB] FAIL random_%0d: got ctrl=%b err=%b stall=%0d flush=%0d expected ctrl=%b err=%b stall=%0d flush=%0d",
                     i, dutCtrl, memErr, stallCnt, flushCnt, e, mErr, mStall, mFlush);
         end
         clockModel();
      end
   endtask

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      reset = 1'b1; idexMemRead = 0; idexRt = 0; ifidRs = 0; ifidRt = 0;
      ifidUseRs = 0; ifidUseRt = 0; idJump = 0; exBranchTaken = 0;
      exmemMemReq = 0; dmemReady = 0;
      test_reset();
      test_load_use();
      test_branch_priority();
      test_mem_wait();
      test_timeout();
      test_boundary_ready();
      test_saturation();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
      $finish;
   end

endmodule
